// File: rtl/hazard_unit.sv
// Stall/flush side of the 5-stage pipeline hazard logic.
// Also keeps saturating stall/redirect counters and a sticky stall timeout.
module hazard_unit #(
   parameter int MAX_STALL = 255,
   parameter int CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             Reset_L,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_ReadsRs,
   input  logic             ID_ReadsRt,
   input  logic             ID_Jump,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_Rw,
   input  logic             EX_BranchTaken,
   input  logic             DMemStall,
   output logic             PCWrite,
   output logic             IFWrite,
   output logic             IFFlush,
   output logic             Bubble,
   output logic             PipeHold,
   output logic [1:0]       AddrSel,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushEvents,
   output logic             StallTimeout
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD_STALL,
      FROZEN
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [15:0]      RUN_MAX = 16'(MAX_STALL);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [15:0]      run_q, run_d;
   logic             timeout_q, timeout_d;

   logic       lu;
   logic       redirect;
   logic       pc_wr, if_wr, if_fl, bub, hold;
   logic [1:0] sel;

   assign lu = EX_MemRead && (EX_Rw != 5'd0) &&
               ((ID_ReadsRs && (ID_Rs == EX_Rw)) ||
                (ID_ReadsRt && (ID_Rt == EX_Rw)));

   // FROZEN resolves like IDLE once memory is ready; only LOAD_STALL
   // suppresses a second load-use bubble.
   always_comb begin
      pc_wr    = 1'b1;
      if_wr    = 1'b1;
      if_fl    = 1'b0;
      bub      = 1'b0;
      hold     = 1'b0;
      sel      = 2'b00;
      redirect = 1'b0;
      state_d  = IDLE;
      if (DMemStall) begin
         pc_wr   = 1'b0;
         if_wr   = 1'b0;
         hold    = 1'b1;
         state_d = FROZEN;
      end else if (EX_BranchTaken) begin
         sel      = 2'b10;
         if_fl    = 1'b1;
         bub      = 1'b1;
         redirect = 1'b1;
      end else if (lu && (state_q != LOAD_STALL)) begin
         pc_wr   = 1'b0;
         if_wr   = 1'b0;
         bub     = 1'b1;
         state_d = LOAD_STALL;
      end else if (ID_Jump) begin
         sel      = 2'b01;
         if_fl    = 1'b1;
         redirect = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_wr && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (redirect && (flush_cnt_q != CNT_MAX))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      run_d = 16'd0;
      if (DMemStall)
         run_d = (run_q == RUN_MAX) ? run_q : run_q + 16'd1;
      timeout_d = timeout_q || (run_d == RUN_MAX);
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q     <= IDLE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         run_q       <= 16'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         run_q       <= run_d;
         timeout_q   <= timeout_d;
      end
   end

   // Reset forces the pipeline into a flushed, non-advancing state.
   assign PCWrite      = Reset_L & pc_wr;
   assign IFWrite      = Reset_L & if_wr;
   assign IFFlush      = ~Reset_L | if_fl;
   assign Bubble       = ~Reset_L | bub;
   assign PipeHold     = Reset_L & hold;
   assign AddrSel      = Reset_L ? sel : 2'b00;
   assign StallCycles  = stall_cnt_q;
   assign FlushEvents  = flush_cnt_q;
   assign StallTimeout = timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit.
// Small counters so saturation is reachable.
module tb_hazard_unit;

   localparam int CNT_W = 4;

   logic             CLK = 1'b0;
   logic             Reset_L;
   logic [4:0]       ID_Rs, ID_Rt, EX_Rw;
   logic             ID_ReadsRs, ID_ReadsRt, ID_Jump;
   logic             EX_MemRead, EX_BranchTaken, DMemStall;
   logic             PCWrite, IFWrite, IFFlush, Bubble, PipeHold;
   logic [1:0]       AddrSel;
   logic [CNT_W-1:0] StallCycles, FlushEvents;
   logic             StallTimeout;
   logic [6:0]       ctrl;

   int n_chk  = 0;
   int n_fail = 0;

   // {PCWrite,IFWrite,IFFlush,Bubble,PipeHold,AddrSel}
   localparam logic [6:0] C_RST  = 7'b0011000;
   localparam logic [6:0] C_NORM = 7'b1100000;
   localparam logic [6:0] C_LU   = 7'b0001000;
   localparam logic [6:0] C_FRZ  = 7'b0000100;
   localparam logic [6:0] C_BR   = 7'b1111010;
   localparam logic [6:0] C_JMP  = 7'b1110001;

   hazard_unit #(.MAX_STALL(4), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .Reset_L(Reset_L),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .ID_ReadsRs(ID_ReadsRs), .ID_ReadsRt(ID_ReadsRt),
      .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead),
      .EX_Rw(EX_Rw), .EX_BranchTaken(EX_BranchTaken),
      .DMemStall(DMemStall),
      .PCWrite(PCWrite), .IFWrite(IFWrite), .IFFlush(IFFlush),
      .Bubble(Bubble), .PipeHold(PipeHold), .AddrSel(AddrSel),
      .StallCycles(StallCycles), .FlushEvents(FlushEvents),
      .StallTimeout(StallTimeout)
   );

   always #5 CLK = ~CLK;

   assign ctrl = {PCWrite, IFWrite, IFFlush, Bubble, PipeHold, AddrSel};

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      ID_Rs = 0; ID_Rt = 0; EX_Rw = 0;
      ID_ReadsRs = 0; ID_ReadsRt = 0; ID_Jump = 0;
      EX_MemRead = 0; EX_BranchTaken = 0; DMemStall = 0;
   endtask

   task automatic set_lu();
      EX_MemRead = 1; EX_Rw = 5; ID_Rs = 5; ID_ReadsRs = 1;
   endtask

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      clr();
      Reset_L = 0;
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_ctrl", 16'(ctrl), 16'(C_RST));
      chk("rst_sc", 16'(StallCycles), 0);
      @(negedge CLK);
      Reset_L = 1;
      #1;
      chk("idle_ctrl", 16'(ctrl), 16'(C_NORM));
      chk("idle_sc", 16'(StallCycles), 0);
      step();

      set_lu(); #1;
      chk("lu_ctrl", 16'(ctrl), 16'(C_LU));
      step(); #1;
      chk("lu_next_ctrl", 16'(ctrl), 16'(C_NORM));
      chk("lu_sc", 16'(StallCycles), 1);
      step(); #1;
      chk("lu_back_idle", 16'(ctrl), 16'(C_LU));
      step();
      clr(); #1;
      chk("lu_sc2", 16'(StallCycles), 2);
      step();

      EX_MemRead = 1; EX_Rw = 0; ID_Rs = 0; ID_ReadsRs = 1; #1;
      chk("neg_r0", 16'(ctrl), 16'(C_NORM));
      step();
      EX_Rw = 5; ID_Rs = 5; ID_ReadsRs = 0; #1;
      chk("neg_nors", 16'(ctrl), 16'(C_NORM));
      ID_Rt = 5; ID_ReadsRt = 1; #1;
      chk("lu_rt", 16'(ctrl), 16'(C_LU));
      step();
      clr(); step();

      set_lu(); EX_BranchTaken = 1; ID_Jump = 1; #1;
      chk("br_ctrl", 16'(ctrl), 16'(C_BR));
      step(); #1;
      chk("br_fe", 16'(FlushEvents), 1);
      chk("br_sc", 16'(StallCycles), 3);
      clr();
      ID_Jump = 1; #1;
      chk("jmp_ctrl", 16'(ctrl), 16'(C_JMP));
      step(); #1;
      chk("jmp_fe", 16'(FlushEvents), 2);
      clr();

      set_lu(); DMemStall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("frz_ctrl%0d", i), 16'(ctrl), 16'(C_FRZ));
         step();
      end
      DMemStall = 0; #1;
      chk("frz_lu_ctrl", 16'(ctrl), 16'(C_LU));
      step(); #1;
      chk("frz_once", 16'(ctrl), 16'(C_NORM));
      chk("frz_sc", 16'(StallCycles), 7);
      chk("frz_to", 16'(StallTimeout), 0);
      step();
      clr();

      DMemStall = 1;
      for (int i = 0; i < 3; i++) step();
      #1;
      chk("to_early", 16'(StallTimeout), 0);
      step(); #1;
      chk("to_set", 16'(StallTimeout), 1);
      DMemStall = 0;
      step(); #1;
      chk("to_sticky", 16'(StallTimeout), 1);
      chk("to_sc", 16'(StallCycles), 11);

      DMemStall = 1;
      for (int i = 0; i < 6; i++) step();
      #1;
      chk("sc_sat", 16'(StallCycles), 15);

      Reset_L = 0; #1;
      chk("mid_rst_ctrl", 16'(ctrl), 16'(C_RST));
      chk("mid_rst_sc", 16'(StallCycles), 0);
      chk("mid_rst_fe", 16'(FlushEvents), 0);
      chk("mid_rst_to", 16'(StallTimeout), 0);
      @(negedge CLK);
      Reset_L = 1;
      DMemStall = 0; #1;
      chk("post_rst_ctrl", 16'(ctrl), 16'(C_NORM));
      step(); #1;
      chk("post_rst_sc", 16'(StallCycles), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core: the stall/flush side of the hazard logic, where ForwardingUnit is the bypass side. It detects hazards that bypassing cannot resolve:
- load-use dependencies,
- taken branches resolved in EX,
- jumps decoded in ID,
- data-memory wait states.

It drives PC write enable, IF/ID write and flush, ID/EX bubble insertion, pipeline freeze and next-PC select. It also keeps saturating performance counters and a sticky stall-timeout flag.

## Interface
- MAX_STALL, 255: consecutive DMemStall cycles after which StallTimeout sets (1..65535)
- CNT_W, 16: width of performance counters
- CLK  in  1  pipeline clock, all state updates on rising edge
- Reset_L  in  1  asynchronous, active-low reset
- ID_Rs, ID_Rt  in  5 each  source registers of instruction in ID
- ID_ReadsRs, ID_ReadsRt  in  1 each  ID instruction actually reads Rs / Rt (Rs not read for shamt shifts; Rt read for R-type, stores, branches)
- ID_Jump  in  1  jump (j/jal/jr) decoded in ID
- EX_MemRead  in  1  instruction in EX is a load
- EX_Rw  in  5  destination register of instruction in EX
- EX_BranchTaken  in  1  branch in EX resolved taken
- DMemStall  in  1  data memory not ready this cycle
- PCWrite  out  1  PC register load enable
- IFWrite  out  1  IF/ID register load enable
- IFFlush  out  1  IF/ID loads NOP
- Bubble  out  1  ID/EX loads NOP control word
- PipeHold  out  1  ID/EX, EX/MEM, MEM/WB hold contents
- AddrSel  out  2  next PC: 00 PC+4, 01 jump target, 10 branch target
- StallCycles  out  CNT_W  cycles with PCWrite=0 since reset, saturating
- FlushEvents  out  CNT_W  branch/jump redirects since reset, saturating
- StallTimeout  out  1  sticky: DMemStall held MAX_STALL consecutive cycles

## Operation
- FSM states:
  - IDLE
  - LOAD_STALL: one bubble already inserted
  - FROZEN: memory wait
- Control outputs are combinational from state and inputs. Counters, run-length counter and StallTimeout are registered.
- Load-use condition LU = EX_MemRead & (EX_Rw≠0) & ((ID_ReadsRs & ID_Rs==EX_Rw) | (ID_ReadsRt & ID_Rt==EX_Rw)).
- Evaluation in IDLE and LOAD_STALL, first match wins:
  1. DMemStall=1: PCWrite=0, IFWrite=0, PipeHold=1, Bubble=0, IFFlush=0. Next state FROZEN.
  2. EX_BranchTaken=1: PCWrite=1, AddrSel=10, IFWrite=1, IFFlush=1, Bubble=1.
     - Squashes both the ID and IF instructions, including any jump in ID.
     - FlushEvents+1. Next state IDLE.
  3. LU=1 and state IDLE: PCWrite=0, IFWrite=0, Bubble=1. Next state LOAD_STALL.
  4. ID_Jump=1: PCWrite=1, AddrSel=01, IFWrite=1, IFFlush=1. FlushEvents+1. Next state IDLE.
  5. Otherwise: PCWrite=1, IFWrite=1, AddrSel=00, all others 0. Next state IDLE.
- LOAD_STALL never re-asserts a load-use stall. The dependency is resolved by ForwardingUnit from MEM.
- FROZEN:
  - Outputs are the same as rule 1 while DMemStall=1.
  - When DMemStall drops, the rules are evaluated as in IDLE (pre-freeze LOAD_STALL context is not retained).
  - Next state follows the matched rule.
- Defaults when not stated: AddrSel=00 and every other control output 0.
- StallCycles increments every non-reset cycle with PCWrite=0.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Run-length counter:
  - Counts consecutive DMemStall=1 cycles and clears on any DMemStall=0 cycle.
  - StallTimeout sets on the cycle the count reaches MAX_STALL and stays set until reset.
- Simultaneous events:
  - DMemStall masks branch, jump and load-use. Those inputs are re-evaluated after the freeze, because upstream registers are held.
  - Branch outranks load-use: the dependent instruction is squashed anyway.

## Timing
- Reset_L=0 forces, asynchronously:
  - state IDLE;
  - counters, run-length counter and StallTimeout to 0;
  - outputs PCWrite=0, IFWrite=0, IFFlush=1, Bubble=1, PipeHold=0, AddrSel=00.
- First rising edge after Reset_L rises evaluates normally.
- Detection-to-effect latency is zero cycles: outputs act on the same rising edge that ends the detection cycle.
- Load-use costs exactly 1 stall cycle. Taken branch costs 2 squashed slots. Jump costs 1 squashed slot.
- Counter and state updates are visible one cycle after the event.
- Reset asserted mid-stall or mid-freeze aborts it immediately. No pending stall is replayed.

## Test plan
- Load-use: EX_MemRead=1, EX_Rw=5, ID_Rs=5, ID_ReadsRs=1:
  - cycle 0: PCWrite=0, IFWrite=0, Bubble=1;
  - next cycle, with inputs unchanged: normal flow, state back to IDLE, StallCycles=1.
- Load-use negatives:
  - EX_Rw=0 → no stall.
  - ID_Rs=5 with ID_ReadsRs=0 → no stall.
- Branch+jump+LU together: EX_BranchTaken=1, ID_Jump=1, LU=1 → AddrSel=10, IFFlush=1, Bubble=1, PCWrite=1, FlushEvents=1.
- Jump: ID_Jump=1 alone → AddrSel=01, IFFlush=1, Bubble=0.
- Freeze: DMemStall=1 for 3 cycles during a load-use → PipeHold=1 and PCWrite=0 for 3 cycles; after release the load-use bubble is inserted once; StallCycles=4.
- Timeout and reset, MAX_STALL=4:
  - DMemStall held 4 cycles → StallTimeout=1 on cycle 4 and stays 1 after DMemStall drops.
  - Reset_L pulsed low mid-freeze → all outputs at reset values immediately, counters 0.
